// File: rtl/neureka_norm_splitter_pkg.sv
// Shared types and constants for the norm splitter.
// Optional perf counter macro: NEUREKA_NORM_SPLITTER_PERF_EN.
package neureka_norm_splitter_pkg;

  localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 288;
  localparam int unsigned NEUREKA_NORM_WORD_W = 32;
  localparam int unsigned NEUREKA_NORM_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } norm_split_state_t;

  typedef struct packed {
    logic                          start;
    logic [NEUREKA_NORM_LEN_W-1:0] len;
  } ctrl_norm_splitter_t;

endpackage

// File: rtl/neureka_norm_splitter.sv
// Splits wide norm beats into OW-bit words, stopping after len_i words.
// Ports: clk_i/rst_ni/clear_i/enable_i, start_i+len_i control,
//   push_* beat stream in, pop_* word stream out, busy_o, done_o,
//   stall_cnt_o when NEUREKA_NORM_SPLITTER_PERF_EN is defined.
module neureka_norm_splitter
  import neureka_norm_splitter_pkg::*;
#(
  parameter int unsigned BW    = NEUREKA_MEM_BANDWIDTH_EXT,
  parameter int unsigned OW    = NEUREKA_NORM_WORD_W,
  parameter int unsigned LEN_W = NEUREKA_NORM_LEN_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic            start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [BW-1:0]   push_data_i,
  input  logic [BW/8-1:0] push_strb_i,
  input  logic            push_valid_i,
  output logic            push_ready_o,
  output logic [OW-1:0]   pop_data_o,
  output logic [OW/8-1:0] pop_strb_o,
  output logic            pop_valid_o,
  input  logic            pop_ready_i,
  output logic            busy_o,
  output logic            done_o
`ifdef NEUREKA_NORM_SPLITTER_PERF_EN
  ,
  output logic [31:0]     stall_cnt_o
`endif
);

  localparam int unsigned NW = BW / OW;
  localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned SW = OW / 8;

  if ((BW % OW) != 0 || (OW % 8) != 0) begin : g_bad_cfg
    $error("neureka_norm_splitter: BW must be a multiple of OW");
  end

  norm_split_state_t state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [BW/8-1:0]   strb_q, strb_d;
  logic              last_word;
  logic              last_idx;

  assign last_word = (rem_q == LEN_W'(1));
  assign last_idx  = (idx_q == IW'(NW - 1));

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    idx_d        = idx_q;
    beat_d       = beat_q;
    strb_d       = strb_q;
    push_ready_o = 1'b0;
    pop_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && start_i) begin
          rem_d   = len_i;
          state_d = (len_i == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        push_ready_o = 1'b1;
        if (enable_i && push_valid_i) begin
          beat_d  = push_data_i;
          strb_d  = push_strb_i;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        pop_valid_o = 1'b1;
        // refill only when the last word of this beat leaves now
        push_ready_o = last_idx & ~last_word & pop_ready_i;
        if (enable_i && pop_ready_i) begin
          rem_d = rem_q - LEN_W'(1);
          if (last_word) begin
            state_d = DONE;
          end else if (last_idx) begin
            if (push_valid_i) begin
              beat_d = push_data_i;
              strb_d = push_strb_i;
              idx_d  = '0;
            end else begin
              state_d = LOAD;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      DONE: begin
        if (enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      strb_q  <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      strb_q  <= strb_d;
    end
  end

  assign pop_data_o = beat_q[idx_q*OW +: OW];
  assign pop_strb_o = strb_q[idx_q*SW +: SW];
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

`ifdef NEUREKA_NORM_SPLITTER_PERF_EN
  logic stall;

  assign stall = (pop_valid_o & ~pop_ready_i)
               | ((state_q == LOAD) & ~push_valid_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (clear_i) begin
      stall_cnt_o <= '0;
    end else if (enable_i) begin
      if (state_q == IDLE && start_i)
        stall_cnt_o <= '0;
      else if (stall && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/neureka_norm_splitter.md
Name: neureka_norm_splitter

Overview:
- Sits directly downstream of the streamer's norm_o source stream and feeds the normquant datapath.
- Accepts wide norm beats (BW bits, from TCDM) and serialises them into OW-bit scale/bias words, one word per cycle.
- Stops after a programmed number of words and discards unused trailing words of the final beat.
- Adds one register stage of buffering with zero-bubble beat refill.

Parameters:
- BW, NEUREKA_MEM_BANDWIDTH_EXT (288): width of incoming beat.
- OW, 32: width of emitted word.
- NW, BW/OW (9): words per beat; must be an integer, elaboration error otherwise.
- LEN_W, 16: width of the word-count field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear; same effect as reset
- enable_i  in  1  when low, no handshake completes and state is frozen
- start_i  in  1  one-cycle pulse; begins a transfer
- len_i  in  LEN_W  total OW-words to emit; sampled on start_i
- push_data_i  in  BW  incoming beat
- push_strb_i  in  BW/8  incoming byte strobes
- push_valid_i  in  1  incoming valid
- push_ready_o  out  1  incoming ready
- pop_data_o  out  OW  emitted word
- pop_strb_o  out  OW/8  emitted strobes
- pop_valid_o  out  1  emitted valid
- pop_ready_i  in  1  emitted ready
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at transfer end

Behaviour:
- Reset/clear values: state IDLE, all counters 0, beat register 0, push_ready_o=0, pop_valid_o=0, busy_o=0, done_o=0.
- Handshake rule: a transfer occurs on valid & ready & enable_i. Valid never depends on ready. Once raised, pop_valid_o and pop_data_o stay stable until the word is accepted.
- States:
  - IDLE: on start_i, latch len_i into rem.
    - If len_i == 0: go to DONE.
    - Otherwise go to LOAD.
  - LOAD: push_ready_o=1. On accept, store the beat and strobes, set idx=0, go to EMIT.
  - EMIT: pop_valid_o=1; pop_data_o = beat[idx*OW +: OW], pop_strb_o = the matching strobe slice.
    - On pop accept: decrement rem.
    - If rem == 1 on that accept: go to DONE; remaining words in the beat are dropped and no further beat is consumed.
    - Else if idx == NW-1: push_ready_o=1 in the same cycle, combinationally gated by pop_ready_i. If a new beat is accepted, idx=0 and stay in EMIT (no bubble). Otherwise go to LOAD.
    - Else idx++.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o = (state != IDLE).
- Latency: the first word is valid 1 cycle after the first beat is accepted. Steady-state throughput is 1 word per cycle.
- start_i outside IDLE is ignored.
- enable_i low freezes state, counters and outputs; no handshakes complete.
- clear_i mid-transfer: return to IDLE next cycle with no done_o pulse; the buffered beat is discarded.
- Arithmetic: rem is unsigned LEN_W wide and never underflows. idx is $clog2(NW) bits and wraps only via the explicit reset to 0.

Optional Feature:
- Macro: NEUREKA_NORM_SPLITTER_PERF_EN.
- When defined: adds output stall_cnt_o, 32 bits.
  - Increments every cycle where pop_valid_o & ~pop_ready_i, or state==LOAD & ~push_valid_i.
  - Saturates at all-ones.
  - Zeroed on start_i, reset and clear_i.
- When undefined: no port, no counter logic.

Decomposition:
- neureka_package additions:
  - Constant NEUREKA_NORM_WORD_W = 32.
  - Enum typedef norm_split_state_t {IDLE, LOAD, EMIT, DONE}.
  - Packed ctrl_norm_splitter_t {start, len}, for use by the controller.
- No sub-module: word select and counters stay inline, since the block is below 300 lines.

Test Plan:
- len=9, one beat with words 0x00..0x08, pop_ready tied 1 → 9 consecutive words 0..8 starting 1 cycle after push accept; done_o at cycle 10; push_ready_o low throughout EMIT.
- len=20, three beats, push_valid always 1 → 20 words with no bubble across the beat boundaries at words 9 and 18; words 20..26 of the third beat never emitted; exactly 3 beats consumed.
- len=4 → words 0..3 emitted, done_o pulses once; the next beat remains pending upstream (push_ready_o=0).
- len=0 start → done_o 1 cycle after start, no push accept, busy_o high for 1 cycle.
- pop_ready toggled 1/0 every cycle with len=9 → each word held stable while stalled; all 9 delivered in 18 cycles. With NEUREKA_NORM_SPLITTER_PERF_EN, stall_cnt_o=9.
- clear_i asserted after word 3 of len=9 → IDLE next cycle, no done_o; a new start with len=2 emits words 0,1 of a fresh beat.
